// File: rtl/dyn_partition_step_sched.sv
// Two-partition counter sequencer: a Johnson phase register arbitrates a shared incrementer, runs until fixpoint or step budget.
// Optional macro SCHED_STEP_COUNT_EN exposes the live step counter on port step_cnt.
module dyn_partition_step_sched #(
  parameter int unsigned CW        = 3,
  parameter int unsigned MAX_STEPS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          step_en,
  input  logic                          req_a,
  input  logic                          req_b,
  output logic [CW-1:0]                 cnt_a,
  output logic [CW-1:0]                 cnt_b,
  output logic [1:0]                    phase,
  output logic                          owner,
  output logic                          busy,
  output logic                          done,
  output logic                          fixpoint,
  output logic                          timeout,
  input  logic                          exp_valid,
  input  logic [2*CW+1:0]               exp_state,
  output logic                          mismatch
`ifdef SCHED_STEP_COUNT_EN
  ,
  output logic [$clog2(MAX_STEPS+1)-1:0] step_cnt
`endif
);

  localparam int unsigned SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d;
  logic [CW-1:0]   cnt_b_q, cnt_b_d;
  logic [1:0]      phase_q, phase_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic            fixpoint_q, fixpoint_d;
  logic            timeout_q, timeout_d;
  logic            mismatch_q, mismatch_d;
  logic            step_owner;

  always_comb begin
    state_d    = state_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    phase_d    = phase_q;
    steps_d    = steps_q;
    fixpoint_d = 1'b0;
    timeout_d  = timeout_q;
    step_owner = phase_q[1] ^ phase_q[0];
    // Shadow compare uses the pre-edge state; a start on the same edge clears it below.
    mismatch_d = mismatch_q | (exp_valid && (exp_state != {phase_q, cnt_b_q, cnt_a_q}));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          cnt_a_d    = '0;
          cnt_b_d    = '0;
          phase_d    = '0;
          steps_d    = '0;
          timeout_d  = 1'b0;
          mismatch_d = 1'b0;
        end
      end
      RUN: begin
        if (step_en) begin
          if (!step_owner && req_a) cnt_a_d = cnt_a_q + CW'(1);
          if (step_owner && req_b)  cnt_b_d = cnt_b_q + CW'(1);
          phase_d = {phase_q[0], ~phase_q[1]};
          if (steps_q != MAX_CNT) steps_d = steps_q + SW'(1);
          // Fixpoint takes priority over budget expiry on the same step.
          if ({phase_d, cnt_b_d, cnt_a_d} == '0) begin
            state_d    = DONE;
            fixpoint_d = 1'b1;
            timeout_d  = 1'b0;
          end else if (steps_d == MAX_CNT) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      phase_q    <= '0;
      steps_q    <= '0;
      fixpoint_q <= 1'b0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      phase_q    <= phase_d;
      steps_q    <= steps_d;
      fixpoint_q <= fixpoint_d;
      timeout_q  <= timeout_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;
  assign phase    = phase_q;
  assign owner    = phase_q[1] ^ phase_q[0];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign fixpoint = fixpoint_q;
  assign timeout  = timeout_q;
  assign mismatch = mismatch_q;
`ifdef SCHED_STEP_COUNT_EN
  assign step_cnt = steps_q;
`endif

endmodule

// File: tb/tb_dyn_partition_step_sched.sv
// Scoreboard bench for dyn_partition_step_sched: a cycle-level reference model queues expected outputs, a monitor compares.
module tb_dyn_partition_step_sched;

  localparam int CW  = 3;
  localparam int MAX = 16;
  localparam int SWD = 2 * CW + 2;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, step_en = 1'b0, req_a = 1'b0, req_b = 1'b0, exp_valid = 1'b0;
  logic [SWD-1:0] exp_state = '0;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic [1:0]     phase;
  logic owner, busy, done, fixpoint, timeout, mismatch;

  always #5 clk = ~clk;

  dyn_partition_step_sched #(.CW(CW), .MAX_STEPS(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .step_en(step_en), .req_a(req_a), .req_b(req_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .phase(phase), .owner(owner), .busy(busy), .done(done),
    .fixpoint(fixpoint), .timeout(timeout), .exp_valid(exp_valid), .exp_state(exp_state),
    .mismatch(mismatch)
  );

  typedef struct packed {
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [1:0]    phase;
    logic owner, busy, done, fixpoint, timeout, mismatch;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase as a position in the Johnson cycle, counters as plain integers.
  logic [1:0] phase_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int  m_mode = 0;  // 0 idle, 1 run, 2 done
  int  m_a = 0, m_b = 0, m_pos = 0, m_steps = 0;
  bit  m_fix = 0, m_tmo = 0, m_mis = 0;

  function automatic logic [SWD-1:0] model_state();
    model_state = {phase_tab[m_pos], CW'(m_b), CW'(m_a)};
  endfunction

  task automatic cyc(input bit r, input bit s, input bit se, input bit ra, input bit rb,
                     input bit ev, input logic [SWD-1:0] es);
    snap_t e;
    bit nm;
    @(negedge clk);
    rst = r; start = s; step_en = se; req_a = ra; req_b = rb; exp_valid = ev; exp_state = es;
    if (r) begin
      m_mode = 0; m_a = 0; m_b = 0; m_pos = 0; m_steps = 0; m_fix = 0; m_tmo = 0; m_mis = 0;
    end else begin
      nm = m_mis || (ev && (es != model_state()));
      m_fix = 0;
      if (m_mode != 1 && s) begin
        m_mode = 1; m_a = 0; m_b = 0; m_pos = 0; m_steps = 0; m_tmo = 0; nm = 0;
      end else if (m_mode == 1 && se) begin
        if (m_pos % 2 == 0) begin if (ra) m_a = (m_a + 1) % (1 << CW); end
        else if (rb) m_b = (m_b + 1) % (1 << CW);
        m_pos = (m_pos + 1) % 4;
        if (m_steps < MAX) m_steps++;
        if (m_a == 0 && m_b == 0 && m_pos == 0) begin m_mode = 2; m_fix = 1; m_tmo = 0; end
        else if (m_steps == MAX) begin m_mode = 2; m_tmo = 1; end
      end
      m_mis = nm;
    end
    e.cnt_a = CW'(m_a); e.cnt_b = CW'(m_b); e.phase = phase_tab[m_pos];
    e.owner = (m_pos % 2 == 1); e.busy = (m_mode == 1); e.done = (m_mode == 2);
    e.fixpoint = m_fix; e.timeout = m_tmo; e.mismatch = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic steps(input int n, input bit ra, input bit rb);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, ra, rb, 0, '0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      snap_t e, a;
      e = exp_q.pop_front();
      a = {cnt_a, cnt_b, phase, owner, busy, done, fixpoint, timeout, mismatch};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_state t=%0t actual a=%0d b=%0d ph=%b own=%b busy=%b done=%b fix=%b tmo=%b mis=%b required a=%0d b=%0d ph=%b own=%b busy=%b done=%b fix=%b tmo=%b mis=%b",
                 $time, a.cnt_a, a.cnt_b, a.phase, a.owner, a.busy, a.done, a.fixpoint, a.timeout, a.mismatch,
                 e.cnt_a, e.cnt_b, e.phase, e.owner, e.busy, e.done, e.fixpoint, e.timeout, e.mismatch);
      end
    end
  end

  initial begin
    int guard;
    logic [SWD-1:0] es;
    bit ev;
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(1, 0, 1, 1, 1, 0, '0);
    cyc(0, 0, 1, 1, 1, 0, '0);          // step_en in IDLE has no effect
    // Full cycle with both requests: fixpoint and budget coincide at step 16, fixpoint wins
    cyc(0, 1, 0, 0, 0, 0, '0);
    steps(16, 1, 1);
    idle(2);
    cyc(0, 0, 1, 1, 1, 0, '0);          // DONE holds
    // No requests: phase-only cycle closes after 4 steps
    cyc(0, 1, 0, 0, 0, 0, '0);
    steps(4, 0, 0);
    idle(1);
    // One early increment, then nothing: budget expiry without fixpoint
    cyc(0, 1, 0, 0, 0, 0, '0);
    steps(1, 1, 0);
    steps(15, 0, 0);
    idle(2);
    // Gated stepping
    cyc(0, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) cyc(0, 0, (i % 2 == 0), 1, 1, 0, '0);
    // Shadow mismatch sticks through the run, start in RUN does not clear it
    cyc(0, 0, 0, 0, 0, 1, SWD'(1));
    steps(3, 1, 1);
    cyc(0, 1, 1, 1, 1, 0, '0);
    steps(20, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, '0);           // start in DONE clears mismatch
    idle(1);
    // Reset mid-run, then restart from zero
    steps(5, 1, 1);
    cyc(1, 0, 1, 1, 1, 0, '0);
    cyc(0, 1, 0, 0, 0, 0, '0);
    steps(3, 1, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ev = ($urandom_range(3) == 0);
      es = ($urandom_range(1) == 0) ? model_state() : SWD'($urandom);
      cyc(($urandom_range(79) == 0), ($urandom_range(9) == 0), ($urandom_range(3) != 0),
          $urandom_range(1), $urandom_range(1), ev, es);
    end
    idle(1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
